// File: rtl/ex_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// slave is the execute stage's view of the bundle; master is the view of the logic around it.
interface ex_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] store_data;
  logic [3:0]       ctrl_in;
  logic [4:0]       dest_in;
  logic             mem_stall;
  logic             stall_out;
  logic             out_valid;
  logic [3:0]       control_signals;
  logic [WIDTH-1:0] Mem_address;
  logic [WIDTH-1:0] Mem_input;
  logic [4:0]       dest_out;

  modport slave (
    input  in_valid, alu_op, operand_a, operand_b, store_data, ctrl_in, dest_in, mem_stall,
    output stall_out, out_valid, control_signals, Mem_address, Mem_input, dest_out
  );

  modport master (
    output in_valid, alu_op, operand_a, operand_b, store_data, ctrl_in, dest_in, mem_stall,
    input  stall_out, out_valid, control_signals, Mem_address, Mem_input, dest_out
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU, iterative MULTU/DIVU into private HI/LO,
// and the EX/MEM pipeline register feeding the memory stage.
module ex_stage #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  ex_if.slave ex
);
  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q, state_d;
  logic [SH_W-1:0]  cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] work_hi_q, work_lo_q, opnd_q;
  logic [WIDTH-1:0] work_hi_d, work_lo_d;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic             busy, stall, accept, is_mul, is_div, last;

  logic             vld_p1;
  logic [3:0]       ctrl_p1;
  logic [WIDTH-1:0] res_p1, sdata_p1;
  logic [4:0]       dest_p1;

  function automatic logic [WIDTH-1:0] alu(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo
  );
    logic signed [WIDTH-1:0] sa, sb;
    logic [SH_W-1:0]         sh;
    sa = a;
    sb = b;
    sh = a[SH_W-1:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return WIDTH'(sa < sb);
      4'd7:    return WIDTH'(a < b);
      4'd8:    return b << sh;
      4'd9:    return b >> sh;
      4'd10:   return sb >>> sh;
      4'd13:   return hi;
      4'd14:   return lo;
      4'd15:   return WIDTH'(b[15:0]) << 16;
      default: return '0;
    endcase
  endfunction

  assign busy   = (state_q != IDLE);
  assign stall  = busy | ex.mem_stall;
  assign accept = ex.in_valid & ~stall;
  assign is_mul = (ex.alu_op == 4'd11);
  assign is_div = (ex.alu_op == 4'd12);
  assign last   = (cnt_q == SH_W'(WIDTH - 1));

  // Iteration datapath: MUL shifts the product right through work_hi:work_lo,
  // DIV shifts the dividend left out of work_lo into the remainder in work_hi.
  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    case (state_q)
      MUL: begin
        work_hi_d = mul_sum[WIDTH:1];
        work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
      end
      DIV: begin
        work_hi_d = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
        work_lo_d = {work_lo_q[WIDTH-2:0], div_ge};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && is_mul) state_d = MUL;
        else if (accept && is_div) state_d = DIV;
      end
      MUL, DIV: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (busy && !last) ? cnt_q + SH_W'(1) : '0;
      if (busy && last) begin
        hi_q <= work_hi_d;
        lo_q <= work_lo_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (is_mul || is_div)) begin
      work_hi_q <= '0;
      work_lo_q <= is_mul ? ex.operand_b : ex.operand_a;
      opnd_q    <= is_mul ? ex.operand_a : ex.operand_b;
    end else if (busy) begin
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
    end
  end

  // EX/MEM boundary (p1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      ctrl_p1  <= '0;
      res_p1   <= '0;
      sdata_p1 <= '0;
      dest_p1  <= '0;
    end else if (!ex.mem_stall) begin
      if (accept && !is_mul && !is_div) begin
        vld_p1   <= 1'b1;
        ctrl_p1  <= ex.ctrl_in;
        res_p1   <= alu(ex.alu_op, ex.operand_a, ex.operand_b, hi_q, lo_q);
        sdata_p1 <= ex.store_data;
        dest_p1  <= ex.dest_in;
      end else begin
        vld_p1  <= 1'b0;
        ctrl_p1 <= '0;
      end
    end
  end

  assign ex.stall_out       = stall;
  assign ex.out_valid       = vld_p1;
  assign ex.control_signals = ctrl_p1;
  assign ex.Mem_address     = res_p1;
  assign ex.Mem_input       = sdata_p1;
  assign ex.dest_out        = dest_p1;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, MULTU/DIVU timing and results, mem_stall, reset abort.
module tb_ex_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n;

  ex_if #(.WIDTH(32)) bus ();

  ex_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic [4:0] d, input logic [31:0] sd);
    bus.in_valid   = 1'b1;
    bus.alu_op     = op;
    bus.operand_a  = a;
    bus.operand_b  = b;
    bus.ctrl_in    = c;
    bus.dest_in    = d;
    bus.store_data = sd;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b, 4'b1000, 5'd1, 32'h0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b);
    chk(tag, bus.Mem_address, exp);
  endtask

  task automatic wait_free(output int cnt);
    cnt = 0;
    while (bus.stall_out === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.mem_stall = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    bus.in_valid = 1'b0;
    #2;
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_ctrl", {28'b0, bus.control_signals}, 32'd0);
    chk("rst_addr", bus.Mem_address, 32'd0);
    chk("rst_min", bus.Mem_input, 32'd0);
    chk("rst_dest", {27'b0, bus.dest_out}, 32'd0);
    chk("rst_stall0", {31'b0, bus.stall_out}, 32'd0);
    bus.mem_stall = 1'b1;
    #1;
    chk("rst_stall1", {31'b0, bus.stall_out}, 32'd1);
    bus.mem_stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    drive(4'd0, 32'd5, 32'd7, 4'b1000, 5'd3, 32'hDEAD_BEEF);
    tick();
    bus.in_valid = 1'b0;
    chk("add_res", bus.Mem_address, 32'd12);
    chk("add_ctrl", {28'b0, bus.control_signals}, 32'h8);
    chk("add_dest", {27'b0, bus.dest_out}, 32'd3);
    chk("add_vld", {31'b0, bus.out_valid}, 32'd1);
    chk("add_sdata", bus.Mem_input, 32'hDEAD_BEEF);
    tick();
    chk("bubble_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("bubble_ctrl", {28'b0, bus.control_signals}, 32'd0);
    chk("bubble_hold", bus.Mem_address, 32'd12);

    alu_chk("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_chk("and", 4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    alu_chk("or", 4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    alu_chk("xor", 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0);
    alu_chk("nor", 4'd5, 32'h0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    alu_chk("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_chk("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_chk("sll", 4'd8, 32'd4, 32'd1, 32'h10);
    alu_chk("srl", 4'd9, 32'd4, 32'h8000_0000, 32'h0800_0000);
    alu_chk("sra", 4'd10, 32'd4, 32'h8000_0000, 32'hF800_0000);
    alu_chk("lui", 4'd15, 32'h0, 32'hABCD_1234, 32'h1234_0000);

    // MULTU 0xFFFFFFFF x 2
    issue(4'd11, 32'hFFFF_FFFF, 32'd2);
    chk("mul_bubble_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("mul_bubble_ctrl", {28'b0, bus.control_signals}, 32'd0);
    wait_free(n);
    chk("mul_stall_cycles", n, 32'd32);
    alu_chk("mfhi_mul", 4'd13, 32'h0, 32'h0, 32'd1);
    alu_chk("mflo_mul", 4'd14, 32'h0, 32'h0, 32'hFFFF_FFFE);

    // MFHI presented during busy must return the new HI (3), not the stale 1
    issue(4'd11, 32'h0001_0000, 32'h0003_0000);
    drive(4'd13, 32'h0, 32'h0, 4'b1000, 5'd2, 32'h0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    chk("mfhi_held_cycles", n, 32'd33);
    chk("mfhi_held_val", bus.Mem_address, 32'd3);
    tick();
    chk("mfhi_once", {31'b0, bus.out_valid}, 32'd0);

    issue(4'd12, 32'd100, 32'd7);
    wait_free(n);
    chk("div_stall_cycles", n, 32'd32);
    alu_chk("mflo_div", 4'd14, 32'h0, 32'h0, 32'd14);
    alu_chk("mfhi_div", 4'd13, 32'h0, 32'h0, 32'd2);

    issue(4'd12, 32'd9, 32'd0);
    wait_free(n);
    chk("div0_stall_cycles", n, 32'd32);
    alu_chk("mflo_div0", 4'd14, 32'h0, 32'h0, 32'hFFFF_FFFF);
    alu_chk("mfhi_div0", 4'd13, 32'h0, 32'h0, 32'd9);

    // mem_stall freezes EX/MEM and blocks the next accept
    drive(4'd0, 32'd1, 32'd2, 4'b1010, 5'd5, 32'h55);
    tick();
    chk("ms_add", bus.Mem_address, 32'd3);
    bus.mem_stall = 1'b1;
    drive(4'd1, 32'd10, 32'd3, 4'b1000, 5'd6, 32'h66);
    #1;
    chk("ms_stall_out", {31'b0, bus.stall_out}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_hold_addr", bus.Mem_address, 32'd3);
      chk("ms_hold_vld", {31'b0, bus.out_valid}, 32'd1);
      chk("ms_hold_ctrl", {28'b0, bus.control_signals}, 32'hA);
      chk("ms_hold_dest", {27'b0, bus.dest_out}, 32'd5);
    end
    bus.mem_stall = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("ms_release_res", bus.Mem_address, 32'd7);
    chk("ms_release_dest", {27'b0, bus.dest_out}, 32'd6);
    chk("ms_release_vld", {31'b0, bus.out_valid}, 32'd1);
    tick();
    chk("ms_no_dup", {31'b0, bus.out_valid}, 32'd0);

    // completion coinciding with mem_stall still updates HI/LO
    issue(4'd11, 32'd3, 32'd4);
    for (int i = 0; i < 31; i++) tick();
    bus.mem_stall = 1'b1;
    tick();
    tick();
    chk("cmp_ms_stall", {31'b0, bus.stall_out}, 32'd1);
    bus.mem_stall = 1'b0;
    #1;
    chk("cmp_ms_free", {31'b0, bus.stall_out}, 32'd0);
    alu_chk("cmp_ms_mflo", 4'd14, 32'h0, 32'h0, 32'd12);

    // reset at iteration 10 of MULTU aborts it and clears HI/LO
    alu_chk("pre_rst_add", 4'd0, 32'd40, 32'd2, 32'd42);
    issue(4'd11, 32'd5, 32'd6);
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", {31'b0, bus.stall_out}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_addr", bus.Mem_address, 32'd0);
    chk("mid_rst_dest", {27'b0, bus.dest_out}, 32'd0);
    chk("mid_rst_stall", {31'b0, bus.stall_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    alu_chk("post_rst_mflo", 4'd14, 32'h0, 32'h0, 32'd0);
    chk("post_rst_vld", {31'b0, bus.out_valid}, 32'd1);
    alu_chk("post_rst_mfhi", 4'd13, 32'h0, 32'h0, 32'd0);
    tick();
    tick();
    alu_chk("idle_hi_kept", 4'd13, 32'h0, 32'h0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
